// File: rtl/cpu_pkg.sv
// Shared definitions for the forwarding/hazard control slice: register width,
// muxD select codes and the in-flight pipeline entry layout.
package cpu_pkg;

  localparam int REG_AW = 3;

  // muxD operand-select codes (2'b11 is reserved and never driven)
  localparam logic [1:0] FWD_RF    = 2'b00;  // register file (data_0)
  localparam logic [1:0] FWD_EXMEM = 2'b01;  // EX/MEM result (data_1)
  localparam logic [1:0] FWD_MEMWB = 2'b10;  // MEM/WB result (data_2)

  // One in-flight instruction as seen by the forwarding logic
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              load;
  } pipe_ent_t;

  localparam int PIPE_ENT_W = $bits(pipe_ent_t);

endpackage

// File: rtl/fwd_sel_cmp.sv
// Combinational comparator: one source register against the EX and MEM
// entries, producing the muxD select. The EX entry is younger and wins.
// Register 0 never forwards; an unused source always selects the regfile.
module fwd_sel_cmp
  import cpu_pkg::*;
#(
  parameter int REG_AW = cpu_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] i_src,
  input  logic              i_used,
  input  logic              i_ex_valid,
  input  logic              i_ex_we,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_mem_valid,
  input  logic              i_mem_we,
  input  logic [REG_AW-1:0] i_mem_rd,
  output logic [1:0]        o_sel
);

  logic w_ex_hit;
  logic w_mem_hit;

  assign w_ex_hit  = i_used & i_ex_valid & i_ex_we &
                     (i_ex_rd != '0) & (i_ex_rd == i_src);
  assign w_mem_hit = i_used & i_mem_valid & i_mem_we &
                     (i_mem_rd != '0) & (i_mem_rd == i_src);

  // Youngest producer has priority
  always_comb begin
    o_sel = FWD_RF;
    if (w_ex_hit) begin
      o_sel = FWD_EXMEM;
    end else if (w_mem_hit) begin
      o_sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding/hazard control: tracks destinations of instructions in EX, MEM
// and WB, registers the muxD selects for the instruction entering EX, raises
// a one-cycle load-use stall and keeps a saturating stall-cycle counter.
// dbg_wb exposes the WB entry {valid, rd, we, load} for debug.
module fwd_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_AW = cpu_pkg::REG_AW,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rd_we,
  input  logic              id_is_load,
  input  logic              flush,
  output logic [1:0]        sel_a,
  output logic [1:0]        sel_b,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count,
  output logic [REG_AW+2:0] dbg_wb
);

  // Entry layout matches cpu_pkg::pipe_ent_t but follows the REG_AW parameter
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              load;
  } ent_t;

  ent_t             r_ex;
  ent_t             r_mem;
  ent_t             r_wb;
  logic [1:0]       r_sel_a;
  logic [1:0]       r_sel_b;
  logic [CNT_W-1:0] r_stall_count;

  logic [1:0]       w_sel_a;
  logic [1:0]       w_sel_b;
  logic             w_hazard;

  fwd_sel_cmp #(.REG_AW(REG_AW)) u_cmp_a (
    .i_src       (id_rs1),
    .i_used      (id_rs1_used),
    .i_ex_valid  (r_ex.valid),
    .i_ex_we     (r_ex.we),
    .i_ex_rd     (r_ex.rd),
    .i_mem_valid (r_mem.valid),
    .i_mem_we    (r_mem.we),
    .i_mem_rd    (r_mem.rd),
    .o_sel       (w_sel_a)
  );

  fwd_sel_cmp #(.REG_AW(REG_AW)) u_cmp_b (
    .i_src       (id_rs2),
    .i_used      (id_rs2_used),
    .i_ex_valid  (r_ex.valid),
    .i_ex_we     (r_ex.we),
    .i_ex_rd     (r_ex.rd),
    .i_mem_valid (r_mem.valid),
    .i_mem_we    (r_mem.we),
    .i_mem_rd    (r_mem.rd),
    .o_sel       (w_sel_b)
  );

  // An EX-stage hit on a load cannot be forwarded yet: the data exists only in WB
  assign w_hazard = id_valid & r_ex.load &
                    ((w_sel_a == FWD_EXMEM) | (w_sel_b == FWD_EXMEM));
  // Flush kills the consumer, so no stall is needed; reset forces it low at once
  assign stall    = w_hazard & ~flush & ~rst;

  assign sel_a       = r_sel_a;
  assign sel_b       = r_sel_b;
  assign stall_count = r_stall_count;
  assign dbg_wb      = r_wb;

  // Advance the pipeline entries, insert bubbles on flush/stall, register sels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex          <= '0;
      r_mem         <= '0;
      r_wb          <= '0;
      r_sel_a       <= FWD_RF;
      r_sel_b       <= FWD_RF;
      r_stall_count <= '0;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      if (flush | stall) begin
        r_ex    <= '0;
        r_sel_a <= FWD_RF;
        r_sel_b <= FWD_RF;
      end else begin
        r_ex.valid <= id_valid;
        r_ex.rd    <= id_rd;
        r_ex.we    <= id_rd_we;
        r_ex.load  <= id_is_load;
        r_sel_a    <= w_sel_a;
        r_sel_b    <= w_sel_b;
      end
      if (stall && (r_stall_count != {CNT_W{1'b1}})) begin
        r_stall_count <= r_stall_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed scenarios followed by random instruction
// streams, checked against a list-of-in-flight-instructions reference model.
// A second instance with a 2-bit counter shares all inputs.
module tb_fwd_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [2:0]  id_rs1;
  logic [2:0]  id_rs2;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic [2:0]  id_rd;
  logic        id_rd_we;
  logic        id_is_load;
  logic        flush;

  logic [1:0]  sel_a, sel_b, sel_a2, sel_b2;
  logic        stall, stall2;
  logic [15:0] stall_count;
  logic [1:0]  stall_count2;
  logic [5:0]  dbg_wb, dbg_wb2;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.REG_AW(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_rd_we(id_rd_we), .id_is_load(id_is_load), .flush(flush),
    .sel_a(sel_a), .sel_b(sel_b), .stall(stall), .stall_count(stall_count),
    .dbg_wb(dbg_wb)
  );

  fwd_hazard_ctrl #(.REG_AW(3), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_rd_we(id_rd_we), .id_is_load(id_is_load), .flush(flush),
    .sel_a(sel_a2), .sel_b(sel_b2), .stall(stall2), .stall_count(stall_count2),
    .dbg_wb(dbg_wb2)
  );

  // ---------------- reference model ----------------
  // Slot 0 = instruction in EX, 1 = MEM, 2 = WB.
  bit         m_v[3];
  logic [2:0] m_rd[3];
  bit         m_we[3];
  bit         m_ld[3];
  logic [1:0] m_sa, m_sb;
  int         m_cnt, m_cnt2;
  int         total, bad;
  bit         last_stall;
  logic       obs_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bool_writes(input int k, input logic [2:0] r);
    return m_v[k] && m_we[k] && (m_rd[k] != 3'd0) && (m_rd[k] == r);
  endfunction

  // Source of an operand: nearest older producer among EX then MEM, else regfile
  function automatic logic [1:0] exp_sel(input logic [2:0] src, input bit used);
    if (!used) return 2'd0;
    for (int k = 0; k < 2; k++)
      if (bool_writes(k, src)) return (k == 0) ? 2'd1 : 2'd2;
    return 2'd0;
  endfunction

  function automatic bit exp_stall();
    bit reads_load;
    reads_load = m_ld[0] &&
                 ((id_rs1_used && bool_writes(0, id_rs1)) ||
                  (id_rs2_used && bool_writes(0, id_rs2)));
    return id_valid && !flush && reads_load;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_v[k] = 0; m_rd[k] = 3'd0; m_we[k] = 0; m_ld[k] = 0;
    end
    m_sa = 2'd0; m_sb = 2'd0; m_cnt = 0; m_cnt2 = 0; last_stall = 0;
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Entered just after a rising edge; drives ID, checks mid-cycle, then advances.
  task automatic cyc(input bit v, input logic [2:0] r1, input logic [2:0] r2,
                     input bit u1, input bit u2, input logic [2:0] rd,
                     input bit we, input bit ld, input bit fl);
    bit st;
    logic [1:0] na, nb;
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rs1_used = u1; id_rs2_used = u2;
    id_rd = rd; id_rd_we = we; id_is_load = ld; flush = fl;
    #3;
    st = exp_stall();
    obs_stall = stall;
    chk("stall", {31'd0, stall}, {31'd0, st});
    chk("stall_c2", {31'd0, stall2}, {31'd0, st});
    chk("sel_a", {30'd0, sel_a}, {30'd0, m_sa});
    chk("sel_b", {30'd0, sel_b}, {30'd0, m_sb});
    chk("stall_count", {16'd0, stall_count}, m_cnt);
    chk("stall_count2", {30'd0, stall_count2}, m_cnt2);
    chk("wb_entry", {26'd0, dbg_wb}, {26'd0, m_v[2], m_rd[2], m_we[2], m_ld[2]});
    na = exp_sel(r1, u1);
    nb = exp_sel(r2, u2);
    @(posedge clk);
    for (int k = 2; k > 0; k--) begin
      m_v[k] = m_v[k-1]; m_rd[k] = m_rd[k-1]; m_we[k] = m_we[k-1]; m_ld[k] = m_ld[k-1];
    end
    if (fl || st) begin
      m_v[0] = 0; m_rd[0] = 3'd0; m_we[0] = 0; m_ld[0] = 0; m_sa = 2'd0; m_sb = 2'd0;
    end else begin
      m_v[0] = v; m_rd[0] = rd; m_we[0] = we; m_ld[0] = ld; m_sa = na; m_sb = nb;
    end
    if (st) begin
      m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : 65535;
      m_cnt2 = (m_cnt2 < 3)     ? m_cnt2 + 1 : 3;
    end
    last_stall = st;
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt_before;
    total = 0; bad = 0;
    rst = 1'b1;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd = 0; id_rd_we = 0; id_is_load = 0; flush = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel_a", {30'd0, sel_a}, 32'd0);
    chk("rst_count", {16'd0, stall_count}, 32'd0);
    rst = 1'b0;

    // ALU chain: r1 written, consumer gets EX/MEM, next consumer gets MEM/WB
    cyc(1, 0, 0, 0, 0, 1, 1, 0, 0);
    cyc(1, 1, 0, 1, 0, 2, 1, 0, 0);
    chk("chain_exmem", {30'd0, sel_a}, 32'd1);
    cyc(1, 1, 0, 1, 0, 0, 0, 0, 0);
    chk("chain_memwb", {30'd0, sel_a}, 32'd2);

    // Double hit on r2: youngest producer wins
    cyc(1, 0, 0, 0, 0, 2, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 2, 1, 0, 0);
    cyc(1, 0, 2, 0, 1, 0, 0, 0, 0);
    chk("double_hit", {30'd0, sel_b}, 32'd1);

    // Load-use on r3: one stall cycle, bubble, then MEM/WB forward
    cyc(1, 0, 0, 0, 0, 3, 1, 1, 0);
    cnt_before = m_cnt;
    cyc(1, 3, 0, 1, 0, 4, 1, 0, 0);
    chk("lu_stall_seen", {31'd0, obs_stall}, 32'd1);
    chk("lu_bubble_sel", {30'd0, sel_a}, 32'd0);
    chk("lu_count", {16'd0, stall_count}, cnt_before + 1);
    cyc(1, 3, 0, 1, 0, 4, 1, 0, 0);
    chk("lu_single_cycle", {31'd0, obs_stall}, 32'd0);
    chk("lu_memwb", {30'd0, sel_a}, 32'd2);

    // Register 0 and unused sources never forward or stall
    cyc(1, 0, 0, 0, 0, 0, 1, 1, 0);
    cyc(1, 0, 0, 1, 1, 0, 0, 0, 0);
    chk("r0_stall", {31'd0, obs_stall}, 32'd0);
    chk("r0_sel_a", {30'd0, sel_a}, 32'd0);
    cyc(1, 0, 0, 0, 0, 4, 1, 1, 0);
    cyc(1, 4, 4, 0, 0, 0, 0, 0, 0);
    chk("unused_stall", {31'd0, obs_stall}, 32'd0);
    chk("unused_sel", {30'd0, sel_a, sel_b}, 32'd0);

    // Flush coinciding with a load-use hazard
    cyc(1, 0, 0, 0, 0, 5, 1, 1, 0);
    cnt_before = m_cnt;
    cyc(1, 5, 0, 1, 0, 0, 0, 0, 1);
    chk("flush_stall", {31'd0, obs_stall}, 32'd0);
    chk("flush_count", {16'd0, stall_count}, cnt_before);
    chk("flush_bubble", {30'd0, sel_a}, 32'd0);

    // Five more load-use stalls: 2-bit counter must sit at 3
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 0, 0, 6, 1, 1, 0);
      cyc(0 == 0, 0, 6, 0, 1, 0, 0, 0, 0);
      cyc(1, 0, 6, 0, 1, 0, 0, 0, 0);
    end
    chk("sat_count2", {30'd0, stall_count2}, 32'd3);

    // Reset asserted mid-stall
    cyc(1, 0, 0, 0, 0, 7, 1, 1, 0);
    id_valid = 1; id_rs1 = 3'd7; id_rs1_used = 1; id_rs2_used = 0;
    id_rd_we = 0; id_is_load = 0; flush = 0;
    #2;
    chk("pre_rst_stall", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_sel", {28'd0, sel_a, sel_b}, 32'd0);
    chk("rst_cnt", {16'd0, stall_count}, 32'd0);
    chk("rst_cnt2", {30'd0, stall_count2}, 32'd0);
    chk("rst_wb", {26'd0, dbg_wb}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Random instruction stream; a stalled ID instruction is re-presented
    for (int i = 0; i < 400; i++) begin
      if (last_stall) begin
        cyc(id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_we,
            id_is_load, ($urandom_range(0, 7) == 0));
      end else begin
        cyc(($urandom_range(0, 9) != 0), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 9) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
